// File: rtl/div_unit.sv
// ============================================================================
// div_unit : multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] opa_i,
   input  logic [XLEN-1:0] opb_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] C_ONE     = XLEN'(1);
   localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CW-1:0]   C_LAST    = CW'(XLEN - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            sel_rem_q, sel_rem_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN:0]   rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvsr_q, dvsr_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            done_q, done_d;

   logic            w_signed;
   logic            w_neg_a;
   logic            w_neg_b;
   logic [XLEN-1:0] w_abs_a;
   logic [XLEN-1:0] w_abs_b;
   logic            w_div0;
   logic            w_ovf;
   logic [XLEN+1:0] w_shift;
   logic [XLEN+1:0] w_trial;
   logic [XLEN-1:0] w_quo_fix;
   logic [XLEN-1:0] w_rem_fix;

   // 100=DIV and 110=REM are signed; every other code behaves unsigned
   assign w_signed = funct3_i[2] & ~funct3_i[0];
   assign w_neg_a  = w_signed & opa_i[XLEN-1];
   assign w_neg_b  = w_signed & opb_i[XLEN-1];
   assign w_abs_a  = w_neg_a ? (~opa_i + C_ONE) : opa_i;
   assign w_abs_b  = w_neg_b ? (~opb_i + C_ONE) : opb_i;
   assign w_div0   = (opb_i == '0);
   assign w_ovf    = w_signed & (opa_i == C_INT_MIN) & (&opb_i);

   // Extra top bit makes the borrow of the trial subtract the sign bit
   assign w_shift  = {rem_q, quo_q[XLEN-1]};
   assign w_trial  = w_shift - {2'b00, dvsr_q};

   assign w_quo_fix = qneg_q ? (~quo_q + C_ONE) : quo_q;
   assign w_rem_fix = rneg_q ? (~rem_q[XLEN-1:0] + C_ONE) : rem_q[XLEN-1:0];

   always_comb begin
      state_d   = state_q;
      sel_rem_d = sel_rem_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvsr_d    = dvsr_q;
      result_d  = result_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i && !flush_i) begin
               sel_rem_d = funct3_i[2] & funct3_i[1];
               cnt_d     = '0;
               dvsr_d    = w_abs_b;
               if (w_div0) begin
                  quo_d   = '1;
                  rem_d   = {1'b0, opa_i};
                  qneg_d  = 1'b0;
                  rneg_d  = 1'b0;
                  state_d = S_FIX;
               end else if (w_ovf) begin
                  quo_d   = C_INT_MIN;
                  rem_d   = '0;
                  qneg_d  = 1'b0;
                  rneg_d  = 1'b0;
                  state_d = S_FIX;
               end else begin
                  quo_d   = w_abs_a;
                  rem_d   = '0;
                  qneg_d  = w_neg_a ^ w_neg_b;
                  rneg_d  = w_neg_a;
                  state_d = S_CALC;
               end
            end
         end

         S_CALC: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               rem_d = w_trial[XLEN+1] ? w_shift[XLEN:0] : w_trial[XLEN:0];
               quo_d = {quo_q[XLEN-2:0], ~w_trial[XLEN+1]};
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == C_LAST) begin
                  state_d = S_FIX;
               end
            end
         end

         S_FIX: begin
            state_d = S_IDLE;
            if (!flush_i) begin
               result_d = sel_rem_q ? w_rem_fix : w_quo_fix;
               done_d   = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         sel_rem_q <= 1'b0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         result_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_rem_q <= sel_rem_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvsr_q    <= dvsr_d;
         result_q  <= result_d;
         done_q    <= done_d;
      end
   end

   assign busy_o   = (state_q != S_IDLE);
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// tb_div_unit : scoreboard bench for div_unit against an arithmetic model
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] opa;
   logic [XLEN-1:0] opb;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   always #5 clk = ~clk;

   div_unit #(.XLEN(XLEN)) dut (
      .clk_i    (clk),
      .reset_i  (rst),
      .start_i  (start),
      .funct3_i (funct3),
      .opa_i    (opa),
      .opb_i    (opb),
      .flush_i  (flush),
      .busy_o   (busy),
      .done_o   (done),
      .result_o (result)
   );

   typedef struct {
      logic [XLEN-1:0] res;
      int unsigned     due;
      string           name;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int unsigned cyc     = 0;
   int          n_pass  = 0;
   int          n_total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
   endtask

   function automatic bit is_special(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      bit sgn = (f == 3'b100) || (f == 3'b110);
      return (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // RISC-V M-extension semantics using the simulator's own division
   function automatic logic [XLEN-1:0] model(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      bit sgn = (f == 3'b100) || (f == 3'b110);
      bit rem = (f == 3'b110) || (f == 3'b111);
      logic signed [XLEN-1:0] sa = a;
      logic signed [XLEN-1:0] sb = b;
      logic [XLEN-1:0] q, r;
      if (b == 0) begin
         q = 32'hFFFF_FFFF; r = a;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 0;
      end else if (sgn) begin
         q = sa / sb; r = sa % sb;
      end else begin
         q = a / b; r = a % b;
      end
      return rem ? r : q;
   endfunction

   // Caller is positioned at a negedge; START is held for one cycle
   task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input bit push, input string nm);
      exp_t e;
      funct3 = f; opa = a; opb = b; start = 1'b1;
      if (push) begin
         e.res  = model(f, a, b);
         e.due  = cyc + (is_special(f, a, b) ? 2 : 34);
         e.name = nm;
         exp_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      for (int i = 0; i < 80; i++) begin
         if (done) begin
            check({nm, "_busy_in_done"}, {31'b0, busy}, 32'd0);
            return;
         end
         @(negedge clk);
      end
      check({nm, "_timeout"}, {31'b0, done}, 32'd1);
   endtask

   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", {31'b0, done}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, "_result"}, result, mon_e.res);
            check({mon_e.name, "_latency"}, cyc, mon_e.due);
         end
      end
   end

   logic [2:0]      d_f[10] = '{3'b100, 3'b100, 3'b110, 3'b110, 3'b101, 3'b111, 3'b100, 3'b111, 3'b100, 3'b110};
   logic [XLEN-1:0] d_a[10] = '{32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'd42, 32'd42, 32'h8000_0000, 32'h8000_0000};
   logic [XLEN-1:0] d_b[10] = '{32'd7, 32'd7, 32'd7, 32'hFFFF_FFF9, 32'd2,
                               32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

   initial begin
      logic [2:0]      rf;
      logic [XLEN-1:0] ra, rb;
      int              pick;

      rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; opa = '0; opb = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_result", result, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(3'b100, 32'd100, 32'd7, 1'b1, "div_100_7");
      check("busy_after_start", {31'b0, busy}, 32'd1);
      wait_done("div_100_7");

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         issue(d_f[i], d_a[i], d_b[i], 1'b1, $sformatf("dir%0d", i));
         wait_done($sformatf("dir%0d", i));
      end

      // START while busy must not disturb the op in flight
      @(negedge clk);
      issue(3'b100, 32'd100, 32'd7, 1'b1, "restart_ignored");
      repeat (3) @(negedge clk);
      funct3 = 3'b101; opa = 32'd999; opb = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_during_restart", {31'b0, busy}, 32'd1);
      wait_done("restart_ignored");

      @(negedge clk);
      issue(3'b100, 32'd1000, 32'd3, 1'b0, "");
      repeat (8) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", {31'b0, busy}, 32'd0);
      check("flush_result", result, model(3'b100, 32'd100, 32'd7));
      repeat (40) @(negedge clk);
      check("flush_result_later", result, model(3'b100, 32'd100, 32'd7));

      flush = 1'b1;
      issue(3'b101, 32'd50, 32'd5, 1'b0, "");
      flush = 1'b0;
      check("flush_start_idle_busy", {31'b0, busy}, 32'd0);
      repeat (5) @(negedge clk);

      issue(3'b100, 32'd1000, 32'd3, 1'b0, "");
      repeat (18) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset_busy", {31'b0, busy}, 32'd0);
      check("midreset_done", {31'b0, done}, 32'd0);
      check("midreset_result", result, 32'd0);
      repeat (40) @(negedge clk);

      // Back-to-back: next START lands in the DONE cycle
      issue(3'b110, 32'hFFFF_FF9C, 32'd7, 1'b1, "b2b_a");
      wait_done("b2b_a");
      issue(3'b111, 32'd12345, 32'd100, 1'b1, "b2b_b");
      wait_done("b2b_b");
      issue(3'b100, 32'd42, 32'd0, 1'b1, "b2b_c");
      wait_done("b2b_c");
      issue(3'b101, 32'hDEAD_BEEF, 32'd17, 1'b1, "b2b_d");
      wait_done("b2b_d");

      for (int i = 0; i < 40; i++) begin
         rf   = 3'($urandom_range(0, 7));
         pick = $urandom_range(0, 7);
         ra   = $urandom;
         rb   = $urandom;
         if (pick == 0) rb = '0;
         else if (pick == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
         else if (pick == 2) rb = 32'($urandom_range(1, 300));
         else if (pick == 3) ra = 32'($urandom_range(0, 1000));
         issue(rf, ra, rb, 1'b1, $sformatf("rnd%0d", i));
         wait_done($sformatf("rnd%0d", i));
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle RV32M divider in the EX stage, covering DIV, DIVU, REM and REMU.
- Operands come from the register file read ports via the ID/EX register: OUT1 is the dividend, OUT2 is the divisor.
- Radix-2 restoring iteration, one quotient bit per cycle.
- Raises BUSY so the hazard logic stalls the front end, and pulses DONE when RESULT is valid for EX/MEM.

Parameters:
- XLEN, 32, operand and result width. The iteration count equals XLEN.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request pulse; sampled only in IDLE.
- FUNCT3  input  3  100=DIV, 101=DIVU, 110=REM, 111=REMU. Other codes are treated as DIVU.
- OPA  input  XLEN  dividend (rs1).
- OPB  input  XLEN  divisor (rs2).
- FLUSH  input  1  abort current operation (branch mispredict/trap).
- BUSY  output  1  high while an operation is in flight.
- DONE  output  1  one-cycle pulse; RESULT is valid in this cycle.
- RESULT  output  XLEN  quotient or remainder; held until the next DONE.

Behaviour:
- Reset: when RESET=1 at a rising edge, the next state is IDLE with BUSY=0, DONE=0, RESULT=0, and all internal registers cleared. RESET has priority over FLUSH and START. Reset mid-operation discards the operation and produces no DONE.
- States: IDLE, CALC, FIX.
- IDLE, START=1 (edge t0):
  - Latch FUNCT3.
  - Signed ops (DIV, REM): take absolute values of OPA and OPB, and record the quotient sign (signA XOR signB) and remainder sign (signA).
  - Special cases bypass CALC and go to FIX with the result precomputed:
    - OPB=0: quotient=all ones (0xFFFFFFFF), remainder=OPA unchanged. Applies to both signed and unsigned ops.
    - Signed overflow (OPA=0x80000000, OPB=0xFFFFFFFF, signed op): quotient=0x80000000, remainder=0.
  - Otherwise: next state CALC, counter=0, partial remainder=0, BUSY=1 after t0.
- CALC, once per edge:
  - Shift {rem, dividend} left by 1.
  - trial = rem - divisor. If trial is non-negative (no borrow in an XLEN+1-bit subtract), rem=trial and the quotient bit is 1; else the quotient bit is 0.
  - After XLEN iterations (edges t1..t32), go to FIX.
- FIX, one edge:
  - Apply sign correction: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Select the quotient for DIV/DIVU or the remainder for REM/REMU, and register it into RESULT.
  - Set DONE=1 and BUSY=0, then return to IDLE.
- Latency, counting from the start edge t0:
  - Normal op: RESULT and DONE update at edge t33, so DONE is high for the cycle after t33.
  - Special case: RESULT and DONE update at edge t1.
- DONE is high for exactly one cycle. It is 0 in every other state and cycle.
- BUSY:
  - Normal ops: 1 during CALC and FIX (cycles t0+ to t33), 0 in the DONE cycle.
  - Special cases: 1 only for the single FIX cycle (t0 to t1), 0 in the DONE cycle.
- START handling:
  - START while BUSY=1 is ignored; operands are not re-sampled.
  - START in the DONE cycle is accepted, since the state is IDLE by then.
- FLUSH:
  - FLUSH=1 in CALC or FIX returns to IDLE at the next edge with BUSY=0 and no DONE. RESULT retains its prior value.
  - FLUSH together with START in IDLE: FLUSH wins and the operation is not started.
- Arithmetic:
  - All negation is two's complement modulo 2^XLEN.
  - The partial remainder register is XLEN+1 bits so the trial subtract does not overflow.
  - Results match the RISC-V M-extension definitions exactly, including truncation toward zero.

Test Plan:
- DIV, OPA=100, OPB=7, one-cycle START → BUSY=1 from the next cycle. DONE pulses exactly 33 cycles after the start edge with RESULT=14 (0x0000000E).
- DIV and REM, OPA=-100 (0xFFFFFF9C), OPB=7 → RESULT=0xFFFFFFF2 (-14) and 0xFFFFFFFE (-2) respectively. Also REM with OPA=100, OPB=-7 → RESULT=2.
- DIVU and REMU, OPA=0xFFFFFFFF, OPB=2 → RESULT=0x7FFFFFFF and 0x00000001.
- Divide by zero: DIV 42/0 → 0xFFFFFFFF; REMU 42/0 → 42 (0x0000002A); both with DONE one cycle after the start edge.
- Overflow: DIV and REM with OPA=0x80000000, OPB=0xFFFFFFFF → RESULT=0x80000000 and 0, with DONE after one cycle.
- Control:
  - START re-asserted with new operands at cycle 5 of a busy op → ignored; the original result 14 is delivered.
  - FLUSH at cycle 10 → BUSY=0 next cycle, no DONE, RESULT unchanged.
  - RESET at cycle 20 → BUSY=0, DONE=0, RESULT=0 next cycle, no DONE.
  - A back-to-back START in the DONE cycle completes correctly.
